// File: rtl/moving_avg_decim_stream.sv
// moving_avg_decim_stream
// Decimates the moving average filter's output stream, buffers the kept samples
// in a small first-word-fall-through FIFO and presents them as an AXI4-Stream
// master with tlast framing. The filter has no backpressure. When the FIFO is
// full, samples are dropped and a sticky overflow flag is raised.
module moving_avg_decim_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int DECIM_WIDTH = 4,
    parameter int FIFO_AW     = 3,
    parameter int FRAME_LEN   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  y_N,
    input  logic                   y_N_valid,
    input  logic [DECIM_WIDTH-1:0] decim,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [FIFO_AW:0]       fifo_level,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [FIFO_AW:0]     LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]     LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]   PTR_ONE    = FIFO_AW'(1);
    localparam logic [DECIM_WIDTH-1:0] DCNT_ONE = DECIM_WIDTH'(1);
    localparam logic [FCNT_W-1:0]    FCNT_ONE   = FCNT_W'(1);
    localparam logic [FCNT_W-1:0]    FCNT_LAST  = FCNT_W'(FRAME_LEN - 1);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0]     r_wrPtr;
    logic [FIFO_AW-1:0]     r_rdPtr;
    logic [FIFO_AW:0]       r_level;
    logic [DECIM_WIDTH-1:0] r_dcnt;
    logic [FCNT_W-1:0]      r_fcnt;
    logic                   r_overflow;

    logic w_accept;
    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    // The valid flag comes only from the registered level. This keeps m_tready
    // out of the m_tvalid path. A simultaneous pop is what lets a push into a
    // full FIFO proceed without dropping the sample.
    always_comb begin
        w_accept = y_N_valid && (r_dcnt == '0);
        w_valid  = (r_level != '0);
        w_pop    = w_valid && m_tready;
        w_full   = (r_level == LEVEL_FULL);
        w_push   = w_accept && (!w_full || w_pop);
        w_drop   = w_accept && !w_push;
    end

    // Decimation counter. A reload samples decim, so a new rate takes effect
    // once the current period ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dcnt <= '0;
        end else if (y_N_valid) begin
            if (r_dcnt == '0) begin
                r_dcnt <= decim;
            end else begin
                r_dcnt <= r_dcnt - DCNT_ONE;
            end
        end
    end

    // Storage array is only written at the tail and is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wrPtr] <= y_N;
        end
    end

    // Pointers wrap naturally. The level is tracked separately so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame beat counter advances per delivered beat and wraps at the frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcnt <= '0;
        end else if (w_pop) begin
            if (r_fcnt == FCNT_LAST) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FCNT_ONE;
            end
        end
    end

    // Sticky overflow flag. A drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Output view of the FIFO head. Data is forced to zero when nothing is valid.
    always_comb begin
        m_tvalid   = w_valid;
        m_tdata    = w_valid ? r_mem[r_rdPtr] : '0;
        m_tlast    = w_valid && (r_fcnt == FCNT_LAST);
        fifo_level = r_level;
        overflow   = r_overflow;
    end

endmodule

// File: tb/tb_moving_avg_decim_stream.sv
// Directed testbench for moving_avg_decim_stream (default parameters: DEPTH=8, FRAME_LEN=8).
module tb_moving_avg_decim_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] y_N;
    logic        y_N_valid;
    logic [3:0]  decim;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    moving_avg_decim_stream dut (
        .clk        (clk),
        .reset      (reset),
        .y_N        (y_N),
        .y_N_valid  (y_N_valid),
        .decim      (decim),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge happen, then settle past it.
    task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                 input logic ready, input logic clr);
        y_N_valid = valid;
        y_N       = data;
        m_tready  = ready;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point. It counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Check every output at once against expected values.
    task automatic checkAll(input string tag, input logic v, input logic [15:0] d,
                            input logic l, input logic [3:0] lvl, input logic o);
        checkOutput({tag, ".tvalid"}, {31'd0, m_tvalid}, {31'd0, v});
        checkOutput({tag, ".tdata"}, {16'd0, m_tdata}, {16'd0, d});
        checkOutput({tag, ".tlast"}, {31'd0, m_tlast}, {31'd0, l});
        checkOutput({tag, ".level"}, {28'd0, fifo_level}, {28'd0, lvl});
        checkOutput({tag, ".ovf"}, {31'd0, overflow}, {31'd0, o});
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] keepMask;
        reset     = 1'b1;
        y_N       = '0;
        y_N_valid = 1'b0;
        decim     = '0;
        m_tready  = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h55, 1'b0, 1'b0);
        reset = 1'b0;
        checkAll("reset", 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);

        // Pass-through: every sample appears one cycle after its edge, with tlast on 8 and 16.
        $display("[TB] pass-through");
        decim = 4'd0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
            checkAll($sformatf("pass%0d", i), 1'b1, 16'(i), (i == 8) || (i == 16), 4'd1, 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkAll("pass_drain", 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);

        // Decimate by 4. decim changes to 1 at index 5; samples 0,4,8,10,12,14 are kept.
        $display("[TB] decimate");
        doReset();
        keepMask = 16'h5511;
        for (int i = 0; i < 16; i++) begin
            decim = (i >= 5) ? 4'd1 : 4'd3;
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
            checkOutput($sformatf("decim%0d.tvalid", i), {31'd0, m_tvalid}, {31'd0, keepMask[i]});
            checkOutput($sformatf("decim%0d.tdata", i), {16'd0, m_tdata},
                        keepMask[i] ? i : 32'd0);
        end

        // Backpressure: ten inputs into a stalled FIFO. The ninth input sets overflow.
        $display("[TB] backpressure");
        doReset();
        decim = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b0, 1'b0);
            checkAll($sformatf("fill%0d", k), 1'b1, 16'd1, 1'b0,
                     (k >= 8) ? 4'd8 : 4'(k), (k >= 9));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkAll("stall", 1'b1, 16'd1, 1'b0, 4'd8, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            m_tready = 1'b1;
            #1;
            checkAll($sformatf("drain%0d", j), 1'b1, 16'(j), (j == 8), 4'(9 - j), 1'b1);
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checkAll("drained", 1'b0, 16'h0, 1'b0, 4'd0, 1'b1);

        // Overflow clear, then the set-wins race and a plain clear.
        $display("[TB] overflow clear");
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_alone", {31'd0, overflow}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 16'h20 + 16'(k), 1'b0, 1'b0);
        end
        checkAll("refill", 1'b1, 16'h21, 1'b0, 4'd8, 1'b0);
        applyStimulus(1'b1, 16'h29, 1'b0, 1'b1);
        checkAll("clr_race", 1'b1, 16'h21, 1'b0, 4'd8, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkAll("clr_after", 1'b1, 16'h21, 1'b0, 4'd8, 1'b0);

        // Push and pop while full: no drop, level holds at 8, head advances.
        $display("[TB] push+pop full");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 16'h30 + 16'(k), 1'b1, 1'b0);
            checkAll($sformatf("fullpp%0d", k), 1'b1, 16'h21 + 16'(k), 1'b0, 4'd8, 1'b0);
        end

        // Reset mid-stream with level 5 and three beats already delivered in the frame.
        $display("[TB] reset mid-stream");
        doReset();
        applyStimulus(1'b1, 16'h41, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h42, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h43, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 16'h50 + 16'(k), 1'b0, 1'b0);
        end
        decim = 4'd2;
        applyStimulus(1'b1, 16'h55, 1'b0, 1'b0);
        checkAll("pre_reset", 1'b1, 16'h51, 1'b0, 4'd5, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 16'hBB, 1'b1, 1'b0);
        reset = 1'b0;
        checkAll("post_reset", 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h61, 1'b0, 1'b0);
        checkAll("first_after_reset", 1'b1, 16'h61, 1'b0, 4'd1, 1'b0);
        decim = 4'd0;
        applyStimulus(1'b1, 16'hEE, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hEE, 1'b0, 1'b0);
        checkOutput("discards.level", {28'd0, fifo_level}, 32'd1);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1'b1, 16'h60 + 16'(k), 1'b0, 1'b0);
        end
        checkOutput("refill8.level", {28'd0, fifo_level}, 32'd8);
        for (int j = 1; j <= 8; j++) begin
            m_tready  = 1'b1;
            y_N_valid = 1'b0;
            #1;
            checkOutput($sformatf("frame%0d.tdata", j), {16'd0, m_tdata}, 32'h60 + j);
            checkOutput($sformatf("frame%0d.tlast", j), {31'd0, m_tlast}, {31'd0, (j == 8)});
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checkAll("final", 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
